// File: rtl/fp32_mul.sv
// fp32_mul: three-stage IEEE-754 single-precision multiplier.
// Flush-to-zero in and out, round to nearest even, fixed latency.
module fp32_mul #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] dina,
   input  logic [31:0] dinb,
   input  logic        valid_in,
   output logic [31:0] result,
   output logic        valid_out
);

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } in_t;

   typedef struct packed {
      logic               s;
      logic               nan;
      logic               inf;
      logic               zero;
      logic signed [9:0]  e;
      logic [47:0]        p;
   } s1_t;

   typedef struct packed {
      logic               s;
      logic               nan;
      logic               inf;
      logic               zero;
      logic signed [9:0]  e;
      logic [22:0]        m;
   } s2_t;

   logic [LATENCY-1:0] vld;
   in_t                s0_q;
   s1_t                s1_d;
   s1_t                s1_q;
   s2_t                s2_d;
   s2_t                s2_q;
   logic [31:0]        res_d;

   logic [7:0]         ea;
   logic [7:0]         eb;
   logic [22:0]        fa;
   logic [22:0]        fb;
   logic               a_zero;
   logic               b_zero;
   logic               a_inf;
   logic               b_inf;
   logic               a_nan;
   logic               b_nan;

   assign ea = s0_q.a[30:23];
   assign eb = s0_q.b[30:23];
   assign fa = s0_q.a[22:0];
   assign fb = s0_q.b[22:0];

   // exp=0 covers true zero and denormals alike
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

   // stage 1: classify, add exponents, multiply significands
   always_comb begin
      s1_d      = '0;
      s1_d.s    = s0_q.a[31] ^ s0_q.b[31];
      s1_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_d.inf  = a_inf | b_inf;
      s1_d.zero = a_zero | b_zero;
      s1_d.e    = $signed({2'b00, ea}) + $signed({2'b00, eb})
                - 10'sd127;
      s1_d.p    = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
   end

   logic [22:0]       m_n;
   logic              g;
   logic              st;
   logic              inc;
   logic signed [9:0] e_n;

   // stage 2: normalise by one bit, round to nearest even
   always_comb begin
      m_n = s1_q.p[45:23];
      g   = s1_q.p[22];
      st  = |s1_q.p[21:0];
      e_n = s1_q.e;
      if (s1_q.p[47]) begin
         m_n = s1_q.p[46:24];
         g   = s1_q.p[23];
         st  = |s1_q.p[22:0];
         e_n = s1_q.e + 10'sd1;
      end
      inc       = g & (st | m_n[0]);
      s2_d      = '0;
      s2_d.s    = s1_q.s;
      s2_d.nan  = s1_q.nan;
      s2_d.inf  = s1_q.inf;
      s2_d.zero = s1_q.zero;
      s2_d.m    = m_n + {22'd0, inc};
      s2_d.e    = e_n;
      // all-ones fraction rounding up wraps to 1.0 at next binade
      if (inc && (&m_n)) begin
         s2_d.e = e_n + 10'sd1;
      end
   end

   // stage 3: specials by priority, range check, pack
   always_comb begin
      res_d = {s2_q.s, s2_q.e[7:0], s2_q.m};
      if (s2_q.nan) begin
         res_d = 32'h7FC0_0000;
      end else if (s2_q.inf) begin
         res_d = {s2_q.s, 8'hFF, 23'd0};
      end else if (s2_q.zero) begin
         res_d = {s2_q.s, 31'd0};
      end else if (s2_q.e >= 10'sd255) begin
         res_d = {s2_q.s, 8'hFF, 23'd0};
      end else if (s2_q.e <= 10'sd0) begin
         res_d = {s2_q.s, 31'd0};
      end
   end

   // valid shift register and output register, cleared at once
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld       <= '0;
         valid_out <= 1'b0;
         result    <= '0;
      end else begin
         vld       <= {vld[LATENCY-2:0], valid_in};
         valid_out <= vld[LATENCY-1];
         if (vld[LATENCY-1]) begin
            result <= res_d;
         end
      end
   end

   // datapath registers run freely; validity lives in vld
   always_ff @(posedge clk) begin
      s0_q <= '{a: dina, b: dinb};
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

endmodule

// File: tb/tb_fp32_mul.sv
// tb_fp32_mul: random and directed stimulus for fp32_mul,
// checked every cycle against an arithmetic reference model.
module tb_fp32_mul;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] dina = '0;
   logic [31:0] dinb = '0;
   logic [31:0] result;
   logic        valid_out;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          edge_cnt = 0;
   bit          exp_v [0:8191];
   logic [31:0] exp_r [0:8191];
   logic [31:0] last_r = '0;

   localparam logic [95:0] VEC [0:10] = '{
      {32'h3FC00000, 32'h40000000, 32'h40400000},
      {32'h3F800001, 32'h3FC00000, 32'h3FC00002},
      {32'h3F800003, 32'h3F800003, 32'h3F800006},
      {32'h7F800000, 32'h00000000, 32'h7FC00000},
      {32'hFF800000, 32'h40000000, 32'hFF800000},
      {32'h7FC12345, 32'h3F800000, 32'h7FC00000},
      {32'h80000000, 32'h3F800000, 32'h80000000},
      {32'h7F7FFFFF, 32'h40000000, 32'h7F800000},
      {32'h00800000, 32'h00800000, 32'h00000000},
      {32'h80800000, 32'h00800000, 32'h80000000},
      {32'h00000001, 32'h3F800000, 32'h00000000}
   };

   fp32_mul #(.LATENCY(3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .dina      (dina),
      .dinb      (dinb),
      .valid_in  (valid_in),
      .result    (result),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt++;

   // exact product of significands, rounded by remainder vs half
   function automatic logic [31:0] ref_mul(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic            s;
      int              xa, xb, e, msb, sh;
      longint unsigned fa, fb, p, q, rem, half;
      bit              za, zb, ia, ib, na, nb;
      s  = a[31] ^ b[31];
      xa = int'(a[30:23]);
      xb = int'(b[30:23]);
      fa = 64'(a[22:0]);
      fb = 64'(b[22:0]);
      za = (xa == 0);
      zb = (xb == 0);
      ia = (xa == 255) && (fa == 0);
      ib = (xb == 255) && (fb == 0);
      na = (xa == 255) && (fa != 0);
      nb = (xb == 255) && (fb != 0);
      if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
      if (ia || ib) return {s, 8'hFF, 23'h0};
      if (za || zb) return {s, 31'h0};
      p    = (fa + (64'd1 << 23)) * (fb + (64'd1 << 23));
      msb  = (p >= (64'd1 << 47)) ? 47 : 46;
      sh   = msb - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      e = xa + xb - 127 + (msb - 46);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] r;
      int          k;
      r = $urandom();
      k = $urandom_range(0, 5);
      case (k)
         1, 2: r[30:23] = 8'($urandom_range(90, 164));
         3: r[30:23] = 8'($urandom_range(0, 4));
         4: r[30:23] = 8'($urandom_range(250, 255));
         5: begin
            r[30:23] = 8'($urandom_range(110, 144));
            r[22:0]  = 23'h7FFFFF ^ 23'($urandom_range(0, 15));
         end
         default: ;
      endcase
      return r;
   endfunction

   // per-cycle compare; result must hold between tokens
   always @(posedge clk) begin
      #1;
      if (exp_v[edge_cnt]) last_r = exp_r[edge_cnt];
      n_cmp++;
      if (valid_out !== exp_v[edge_cnt] || result !== last_r) begin
         n_bad++;
         $display("FAIL stream edge %0d: valid_out=%0b result=%08h, want %0b %08h",
                  edge_cnt, valid_out, result, exp_v[edge_cnt], last_r);
      end
   end

   task automatic drive(input bit v, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      valid_in = v;
      dina     = a;
      dinb     = b;
      if (v) begin
         exp_v[edge_cnt + 4] = 1'b1;
         exp_r[edge_cnt + 4] = ref_mul(a, b);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %08h, want %08h", name, got, want);
      end
   endtask

   initial begin
      @(negedge clk);
      check("reset_result", result, 32'h0);
      check("reset_valid", {31'h0, valid_out}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         logic [95:0] v;
         v = VEC[i];
         check($sformatf("model_vec%0d", i),
               ref_mul(v[95:64], v[63:32]), v[31:0]);
      end

      drive(1'b1, 32'h3FC00000, 32'h40000000);
      idle(3);
      check("latency_early", {31'h0, valid_out}, 32'h0);
      @(negedge clk);
      check("latency_valid", {31'h0, valid_out}, 32'h1);
      check("latency_result", result, 32'h40400000);

      for (int i = 0; i < 11; i++) begin
         logic [95:0] v;
         v = VEC[i];
         drive(1'b1, v[95:64], v[63:32]);
      end
      idle(5);

      for (int i = 0; i < 8; i++) drive(1'b1, rnd_fp(), rnd_fp());
      idle(2);
      for (int i = 0; i < 3; i++) drive(1'b1, rnd_fp(), rnd_fp());
      idle(5);

      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h3F800000 | 32'(i + 1), 32'h40000000);
      end
      @(negedge clk);
      check("pre_reset_valid", {31'h0, valid_out}, 32'h1);
      rstn     = 1'b0;
      valid_in = 1'b0;
      for (int i = 1; i <= 5; i++) exp_v[edge_cnt + i] = 1'b0;
      last_r = '0;
      #1;
      check("mid_reset_valid", {31'h0, valid_out}, 32'h0);
      check("mid_reset_result", result, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b1, 32'h40400000, 32'h40400000);
      idle(3);
      @(negedge clk);
      check("post_reset_valid", {31'h0, valid_out}, 32'h1);
      check("post_reset_result", result, 32'h41100000);
      idle(2);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) != 0) drive(1'b1, rnd_fp(), rnd_fp());
         else drive(1'b0, $urandom(), $urandom());
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
